// File: rtl/ts_queue_sched_if.sv
// ============================================================================
// Module   : ts_queue_sched_if
// Brief    : Queue-scheduler bus bundling gate-control, FIFO and EBM signals.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ts_queue_sched_if #(
  parameter int DESC_W = 24
);
  logic [3:0]        in_ts_schedule_valid;
  logic [3:0]        in_ts_q_empty;
  logic [DESC_W-1:0] in_ts_q0_desc;
  logic [DESC_W-1:0] in_ts_q1_desc;
  logic [DESC_W-1:0] in_ts_q2_desc;
  logic [DESC_W-1:0] in_ts_q3_desc;
  logic [3:0]        out_ts_q_rden;
  logic              out_ts_q2_rden;
  logic [10:0]       out_ts_pkt_len;
  logic              out_ts_desc_wr;
  logic [DESC_W-1:0] out_ts_desc;
  logic [1:0]        out_ts_desc_qid;
  logic              in_ts_ebm_done;
  logic              out_ts_timeout;
  logic              out_ts_busy;

  modport slave (
    input  in_ts_schedule_valid, in_ts_q_empty,
    input  in_ts_q0_desc, in_ts_q1_desc, in_ts_q2_desc, in_ts_q3_desc,
    input  in_ts_ebm_done,
    output out_ts_q_rden, out_ts_q2_rden, out_ts_pkt_len,
    output out_ts_desc_wr, out_ts_desc, out_ts_desc_qid,
    output out_ts_timeout, out_ts_busy
  );

  modport master (
    output in_ts_schedule_valid, in_ts_q_empty,
    output in_ts_q0_desc, in_ts_q1_desc, in_ts_q2_desc, in_ts_q3_desc,
    output in_ts_ebm_done,
    input  out_ts_q_rden, out_ts_q2_rden, out_ts_pkt_len,
    input  out_ts_desc_wr, out_ts_desc, out_ts_desc_qid,
    input  out_ts_timeout, out_ts_busy
  );
endinterface

`default_nettype wire

// File: rtl/ts_queue_sched.sv
// ============================================================================
// Module   : ts_queue_sched
// Brief    : Priority transmit scheduler: pops one queue head per grant, hands
//            it to the EBM and waits for done or watchdog expiry.
//            Optional macro TS_Q23_RR_EN: round-robin between Q2 and Q3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ts_queue_sched #(
  parameter int DESC_W  = 24,
  parameter int TIMEOUT = 4095
) (
  input  logic               clk,
  input  logic               rst_n,
  ts_queue_sched_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    RD_S    = 2'd1,
    ISSUE_S = 2'd2,
    WAIT_S  = 2'd3
  } state_t;

  localparam logic [15:0] c_timeout = 16'(TIMEOUT);

  state_t            r_state;
  logic [1:0]        r_sel;
  logic [1:0]        r_qid;
  logic [DESC_W-1:0] r_desc;
  logic [15:0]       r_wdog;
  logic [3:0]        r_rden;
  logic              r_desc_wr;
  logic              r_timeout;

  logic [3:0]        w_elig;
  logic [1:0]        w_sel;
  logic [DESC_W-1:0] w_head;
  logic [15:0]       w_wdog_nxt;
  logic              w_expire;

  assign w_elig = bus.in_ts_schedule_valid & ~bus.in_ts_q_empty;

`ifdef TS_Q23_RR_EN
  logic r_rr;

  always_comb begin
    w_sel = 2'd0;
    if (w_elig[0])                    w_sel = 2'd0;
    else if (w_elig[1])               w_sel = 2'd1;
    else if (w_elig[2] && w_elig[3])  w_sel = r_rr ? 2'd3 : 2'd2;
    else if (w_elig[2])               w_sel = 2'd2;
    else if (w_elig[3])               w_sel = 2'd3;
  end

  // Pointer advances on every Q2/Q3 grant, even when only one was eligible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= 1'b0;
    end else if (r_state == IDLE_S && w_elig != 4'd0 && w_sel[1]) begin
      r_rr <= ~r_rr;
    end
  end
`else
  always_comb begin
    w_sel = 2'd0;
    if (w_elig[0])       w_sel = 2'd0;
    else if (w_elig[1])  w_sel = 2'd1;
    else if (w_elig[2])  w_sel = 2'd2;
    else if (w_elig[3])  w_sel = 2'd3;
  end
`endif

  always_comb begin
    w_head = bus.in_ts_q0_desc;
    case (r_sel)
      2'd0:    w_head = bus.in_ts_q0_desc;
      2'd1:    w_head = bus.in_ts_q1_desc;
      2'd2:    w_head = bus.in_ts_q2_desc;
      default: w_head = bus.in_ts_q3_desc;
    endcase
  end

  assign w_wdog_nxt = (r_wdog == 16'hFFFF) ? r_wdog : r_wdog + 16'd1;
  assign w_expire   = (w_wdog_nxt >= c_timeout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE_S;
      r_sel     <= 2'd0;
      r_qid     <= 2'd0;
      r_desc    <= '0;
      r_wdog    <= 16'd0;
      r_rden    <= 4'd0;
      r_desc_wr <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_rden    <= 4'd0;
      r_desc_wr <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        IDLE_S: begin
          if (w_elig != 4'd0) begin
            r_sel   <= w_sel;
            r_rden  <= 4'(4'b0001 << w_sel);
            r_state <= RD_S;
          end
        end
        RD_S: begin
          r_desc    <= w_head;
          r_qid     <= r_sel;
          r_desc_wr <= 1'b1;
          r_state   <= ISSUE_S;
        end
        ISSUE_S: begin
          r_wdog  <= 16'd0;
          r_state <= WAIT_S;
        end
        WAIT_S: begin
          // Done takes precedence over a coincident watchdog expiry.
          if (bus.in_ts_ebm_done) begin
            r_state <= IDLE_S;
          end else begin
            r_wdog <= w_wdog_nxt;
            if (w_expire) begin
              r_timeout <= 1'b1;
              r_state   <= IDLE_S;
            end
          end
        end
        default: r_state <= IDLE_S;
      endcase
    end
  end

  assign bus.out_ts_q_rden   = r_rden;
  assign bus.out_ts_q2_rden  = r_rden[2];
  assign bus.out_ts_pkt_len  = (r_state == RD_S) ? w_head[10:0] : 11'd0;
  assign bus.out_ts_desc_wr  = r_desc_wr;
  assign bus.out_ts_desc     = r_desc;
  assign bus.out_ts_desc_qid = r_qid;
  assign bus.out_ts_timeout  = r_timeout;
  assign bus.out_ts_busy     = (r_state != IDLE_S);

endmodule

`default_nettype wire

// File: tb/tb_ts_queue_sched.sv
// ============================================================================
// Module   : tb_ts_queue_sched
// Brief    : Directed, table-driven bench for ts_queue_sched (TIMEOUT = 10).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ts_queue_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ts_queue_sched_if #(.DESC_W(24)) bus ();

  ts_queue_sched #(.DESC_W(24), .TIMEOUT(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  sv;
    logic [3:0]  empty;
    logic [3:0]  rden;
    logic [10:0] len;
    logic [23:0] desc;
    logic [1:0]  qid;
  } vec_t;

  vec_t vt[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_ts_schedule_valid = 4'd0;
    bus.in_ts_ebm_done = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Issue one packet, check RD/ISSUE/WAIT cycles, then complete it with done.
  task automatic run_vec(input vec_t v, input string tag);
    bus.in_ts_q_empty        = v.empty;
    bus.in_ts_schedule_valid = v.sv;
    tick();
    bus.in_ts_schedule_valid = 4'd0;
    chk({tag, "_rden"},    32'(bus.out_ts_q_rden),  32'(v.rden));
    chk({tag, "_q2rden"},  32'(bus.out_ts_q2_rden), 32'(v.rden[2]));
    chk({tag, "_pktlen"},  32'(bus.out_ts_pkt_len), 32'(v.len));
    tick();
    chk({tag, "_descwr"},  32'(bus.out_ts_desc_wr),  32'd1);
    chk({tag, "_desc"},    32'(bus.out_ts_desc),     32'(v.desc));
    chk({tag, "_qid"},     32'(bus.out_ts_desc_qid), 32'(v.qid));
    chk({tag, "_len0"},    32'(bus.out_ts_pkt_len),  32'd0);
    tick();
    chk({tag, "_descwr0"}, 32'(bus.out_ts_desc_wr), 32'd0);
    chk({tag, "_busy"},    32'(bus.out_ts_busy),    32'd1);
    bus.in_ts_ebm_done = 1'b1;
    tick();
    bus.in_ts_ebm_done = 1'b0;
    chk({tag, "_idle"},    32'(bus.out_ts_busy),    32'd0);
  endtask

  initial begin
    vec_t rr;
    logic [1:0] exp_qid[4];
    int seen;

    bus.in_ts_schedule_valid = 4'd0;
    bus.in_ts_q_empty        = 4'd0;
    bus.in_ts_q0_desc        = 24'h00A055;
    bus.in_ts_q1_desc        = 24'h00B0A1;
    bus.in_ts_q2_desc        = 24'h003040;
    bus.in_ts_q3_desc        = 24'h7FF7FF;
    bus.in_ts_ebm_done       = 1'b0;

    vt[0] = '{4'b0100, 4'b0000, 4'b0100, 11'h040, 24'h003040, 2'd2};
    vt[1] = '{4'b1111, 4'b0001, 4'b0010, 11'h0A1, 24'h00B0A1, 2'd1};
    vt[2] = '{4'b1111, 4'b0000, 4'b0001, 11'h055, 24'h00A055, 2'd0};
    vt[3] = '{4'b1000, 4'b0000, 4'b1000, 11'h7FF, 24'h7FF7FF, 2'd3};
    vt[4] = '{4'b1010, 4'b0010, 4'b1000, 11'h7FF, 24'h7FF7FF, 2'd3};
    vt[5] = '{4'b0110, 4'b0000, 4'b0010, 11'h0A1, 24'h00B0A1, 2'd1};

    do_reset();
    chk("rst_rden",    32'(bus.out_ts_q_rden),   32'd0);
    chk("rst_descwr",  32'(bus.out_ts_desc_wr),  32'd0);
    chk("rst_desc",    32'(bus.out_ts_desc),     32'd0);
    chk("rst_qid",     32'(bus.out_ts_desc_qid), 32'd0);
    chk("rst_timeout", 32'(bus.out_ts_timeout),  32'd0);
    chk("rst_busy",    32'(bus.out_ts_busy),     32'd0);
    chk("rst_pktlen",  32'(bus.out_ts_pkt_len),  32'd0);

    for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("v%0d", i));

    // Eligible queue is empty: no grant
    bus.in_ts_q_empty = 4'b0100;
    bus.in_ts_schedule_valid = 4'b0100;
    tick();
    bus.in_ts_schedule_valid = 4'd0;
    chk("empty_rden", 32'(bus.out_ts_q_rden), 32'd0);
    chk("empty_busy", 32'(bus.out_ts_busy),   32'd0);
    bus.in_ts_q_empty = 4'd0;

    // Schedule pulse during WAIT ignored; done outside WAIT ignored
    bus.in_ts_schedule_valid = 4'b0100;
    tick();
    bus.in_ts_schedule_valid = 4'd0;
    bus.in_ts_ebm_done = 1'b1;
    tick();
    bus.in_ts_ebm_done = 1'b0;
    tick();
    chk("early_done_busy", 32'(bus.out_ts_busy), 32'd1);
    bus.in_ts_schedule_valid = 4'b0001;
    tick();
    bus.in_ts_schedule_valid = 4'd0;
    chk("wait_sv_rden", 32'(bus.out_ts_q_rden), 32'd0);
    tick();
    chk("wait_sv_rden2", 32'(bus.out_ts_q_rden), 32'd0);
    bus.in_ts_ebm_done = 1'b1;
    tick();
    bus.in_ts_ebm_done = 1'b0;
    chk("wait_done_idle", 32'(bus.out_ts_busy), 32'd0);
    tick();
    chk("not_latched_rden", 32'(bus.out_ts_q_rden), 32'd0);
    run_vec(vt[0], "after_wait");

    // Watchdog expiry: pulse lands 10 cycles after entering WAIT
    bus.in_ts_schedule_valid = 4'b0001;
    tick();
    bus.in_ts_schedule_valid = 4'd0;
    tick();
    seen = 0;
    for (int k = 1; k <= 40 && seen == 0; k++) begin
      tick();
      if (bus.out_ts_timeout === 1'b1) seen = k;
    end
    chk("to_cycle", 32'(seen), 32'd11);
    chk("to_idle",  32'(bus.out_ts_busy), 32'd0);
    tick();
    chk("to_pulse_len", 32'(bus.out_ts_timeout), 32'd0);

    // Done on the expiry cycle wins
    bus.in_ts_schedule_valid = 4'b0001;
    tick();
    bus.in_ts_schedule_valid = 4'd0;
    tick();
    for (int k = 1; k <= 10; k++) tick();
    bus.in_ts_ebm_done = 1'b1;
    tick();
    bus.in_ts_ebm_done = 1'b0;
    chk("done_wins_to",   32'(bus.out_ts_timeout), 32'd0);
    chk("done_wins_idle", 32'(bus.out_ts_busy),    32'd0);
    tick();
    chk("done_wins_to2",  32'(bus.out_ts_timeout), 32'd0);

    // Reset asserted during RD
    bus.in_ts_schedule_valid = 4'b0100;
    tick();
    bus.in_ts_schedule_valid = 4'd0;
    chk("rstrd_pre_rden", 32'(bus.out_ts_q_rden), 32'b0100);
    rst_n = 1'b0;
    #1;
    chk("rstrd_rden", 32'(bus.out_ts_q_rden), 32'd0);
    chk("rstrd_busy", 32'(bus.out_ts_busy),   32'd0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.out_ts_desc_wr !== 1'b0 || bus.out_ts_busy !== 1'b0) seen++;
    end
    chk("rstrd_quiet", 32'(seen), 32'd0);

    // Q2/Q3 arbitration, fresh pointer
    do_reset();
`ifdef TS_Q23_RR_EN
    exp_qid = '{2'd2, 2'd3, 2'd2, 2'd3};
`else
    exp_qid = '{2'd2, 2'd2, 2'd2, 2'd2};
`endif
    for (int i = 0; i < 4; i++) begin
      rr.sv    = 4'b1100;
      rr.empty = 4'b0000;
      rr.qid   = exp_qid[i];
      rr.rden  = (exp_qid[i] == 2'd2) ? 4'b0100 : 4'b1000;
      rr.len   = (exp_qid[i] == 2'd2) ? 11'h040 : 11'h7FF;
      rr.desc  = (exp_qid[i] == 2'd2) ? 24'h003040 : 24'h7FF7FF;
      run_vec(rr, $sformatf("rr%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ts_queue_sched.md
Name: ts_queue_sched

Overview:
Transmit scheduler stage directly downstream of the gate-control block. Consumes the 4-bit per-queue schedule-valid pulse and picks one queue by priority. Pops that queue's head packet descriptor and hands the descriptor to the egress buffer manager (EBM). Holds off further scheduling until EBM reports the packet done or a watchdog expires. Drives the Q2 read strobe and packet length that the gate control uses for token consumption.

Parameters:
DESC_W, 24, descriptor width; [10:0] pkt_len in bytes, [22:11] buffer id, [23] reserved.
TIMEOUT, 4095, WAIT_S watchdog limit in cycles; range 1..65535.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
in_ts_schedule_valid  in  4  from gate control; bit n = queue n eligible; 1-cycle pulse.
in_ts_q_empty  in  4  per-queue descriptor FIFO empty flags.
in_ts_q0_desc, in_ts_q1_desc, in_ts_q2_desc, in_ts_q3_desc  in  DESC_W each  show-ahead FIFO head data.
out_ts_q_rden  out  4  one-hot FIFO read strobe.
out_ts_q2_rden  out  1  equals out_ts_q_rden[2]; to gate control.
out_ts_pkt_len  out  11  selected head pkt_len; to gate control.
out_ts_desc_wr  out  1  descriptor valid pulse to EBM.
out_ts_desc  out  DESC_W  descriptor to EBM.
out_ts_desc_qid  out  2  source queue of out_ts_desc.
in_ts_ebm_done  in  1  EBM 1-cycle pulse: packet finished (sent or discarded).
out_ts_timeout  out  1  1-cycle pulse on watchdog expiry.
out_ts_busy  out  1  high in any state except IDLE_S.

Behaviour:
- Reset: all outputs 0; state IDLE_S; watchdog counter 0; RR pointer 0.
- Eligibility mask: elig = in_ts_schedule_valid & ~in_ts_q_empty.
- Priority: Q0 > Q1 > Q2 > Q3 (strict).
- IDLE_S: if elig != 0, register sel = highest-priority set bit and go to RD_S. Otherwise stay.
- RD_S (one cycle):
  - out_ts_q_rden[sel] = 1; all other rden bits 0.
  - out_ts_pkt_len = selected head desc[10:0], driven combinationally in this cycle only; 0 otherwise.
  - Capture the head descriptor into a register. Go to ISSUE_S.
- ISSUE_S (one cycle): out_ts_desc_wr = 1; out_ts_desc and out_ts_desc_qid from registers. Clear the watchdog and go to WAIT_S.
- out_ts_desc and out_ts_desc_qid hold their value until the next ISSUE_S.
- WAIT_S:
  - in_ts_ebm_done -> IDLE_S.
  - Otherwise the watchdog increments. When the count reaches TIMEOUT, pulse out_ts_timeout for 1 cycle and go to IDLE_S.
  - Done and expiry in the same cycle: done wins; no timeout pulse.
- Latency: schedule pulse at cycle T -> rden at T+1 -> desc_wr at T+2. Minimum 4 cycles from one issue to the next.
- in_ts_schedule_valid outside IDLE_S: ignored and not latched.
- in_ts_ebm_done outside WAIT_S: ignored.
- in_ts_schedule_valid with all eligible queues empty: stay in IDLE_S; no rden.
- Watchdog counter: 16 bits, saturating; never wraps.
- Reset mid-operation: immediate return to IDLE_S; any in-flight rden/desc_wr is dropped.

Optional Feature:
Macro TS_Q23_RR_EN.
- Defined: Q0 and Q1 keep strict priority. When Q0 and Q1 are not eligible and both Q2 and Q3 are eligible, the choice alternates by a 1-bit RR pointer. The pointer toggles only when Q2 or Q3 is actually granted; reset value favours Q2. If only one of Q2/Q3 is eligible, that one is granted and the pointer still toggles.
- Undefined: pure strict priority; no pointer logic is synthesized.

Test Plan:
- Reset release, schedule_valid=4'b0100, q_empty=0, q2_desc=24'h00_3040 -> T+1: q_rden=4'b0100, q2_rden=1, pkt_len=11'h040. T+2: desc_wr=1, desc=24'h003040, qid=2. busy until done.
- schedule_valid=4'b1111, q_empty=4'b0001 -> Q1 granted, rden=4'b0010, qid=1.
- In WAIT_S, schedule_valid=4'b0001 pulses -> no rden. Then ebm_done -> IDLE_S next cycle. A new pulse is then served.
- TIMEOUT=10, no ebm_done -> out_ts_timeout pulses exactly 10 cycles after entering WAIT_S, state returns to IDLE_S. Repeat with done on the expiry cycle -> no timeout pulse.
- rst_n asserted during RD_S -> rden drops in the same cycle; after release busy=0 and no desc_wr appears.
- With TS_Q23_RR_EN, schedule_valid=4'b1100 repeated 4 times with done after each -> qid sequence 2,3,2,3. Without the macro -> 2,2,2,2.
